stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Time-multiplexed 4-digit seven-segment driver that consumes the stopwatch's four BCD digit outputs (min_l, min_r, sec_l, sec_r) and drives the board's shared segment bus and per-digit anodes. Adds adjust-mode digit blinking, pause indication on the colon decimal point, optional leading-zero blanking, and anti-ghosting dead time. It sits between the stopwatch counter and the top-level display pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); must be at least 2.
- GHOST, 4: dead cycles at the start of each slot during which all anodes are off; must be less than REFRESH_DIV.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be at least 1.
- ACTIVE_LOW, 1: 1 means seg, dp and an are driven active-low; 0 means active-high.

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- min_l, min_r, sec_l, sec_r  in  5 each  digit values from the counter
- paused  in  1  stopwatch paused
- adj_en  in  1  adjust mode active
- adj_sel  in  3  adjust digit: 0=min_l, 1=min_r, 2=sec_l, 3=sec_r; values 4–7 select no digit
- blank_lz  in  1  blank min_l when it is 0
- seg  out  7  segments; bit0 = a through bit6 = g
- dp  out  1  decimal point
- an  out  4  anodes; an[0] = sec_r (rightmost), an[3] = min_l

## Operation
- **Scan counter:** cnt runs 0..REFRESH_DIV-1. On the terminal count, slot advances 0→1→2→3→0.
  - Slot mapping: 0 = sec_r, 1 = sec_l, 2 = min_r, 3 = min_l.
- **Snapshot:** all four digit inputs are latched together in the cycle where slot==0 and cnt==0. This includes the first cycle after reset. The displayed frame is therefore never torn by a counter update mid-frame.
- **Decode (per digit):**
  - 0–9: standard patterns; active-high hex values are 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - 10–15: dash (g only, 0x40).
  - 16–31: blank.
- **Blink:** blink counter runs 0..BLINK_DIV-1; blink_phase toggles on its terminal count.
  - A digit is blanked while adj_en=1, adj_sel selects that slot, and blink_phase=1.
- **Leading zero:** if blank_lz=1 and snapshot min_l==0, slot 3 is blanked. Exception: while adj_en=1 and adj_sel=0, the digit shows normally, subject only to blink.
- **Decimal point:**
  - Lit only in slot 2 (the colon position).
  - Steady when paused=0.
  - When paused=1, lit only while blink_phase=0.
- **Dead time:** while cnt<GHOST, an is all inactive. seg and dp still carry the new slot's value.
- **Polarity:** with ACTIVE_LOW=1, seg, dp and an are inverted at the output register.

## Timing
- All outputs are registered.
- Output latency:
  - Outputs in cycle T+1 reflect slot, cnt and blink state in cycle T.
  - They also reflect the snapshot as it stood in cycle T, so a snapshot load in cycle T first appears at T+1.
- Live inputs (paused, adj_en, adj_sel, blank_lz) are sampled every cycle with 1-cycle latency. They are not snapshotted.
- **Reset values:**
  - cnt=0, slot=0, blink counter=0, blink_phase=0, snapshot=0.
  - an all inactive, seg all inactive, dp inactive.
- **First active frame after reset release:**
  - Snapshot is captured in the first cycle.
  - an[0] goes active at the cycle after cnt==GHOST.
- **Reset mid-slot:** outputs go inactive in the cycle after rst is sampled high. Scan restarts from slot 0.
- **Per slot:** an[k] is active for REFRESH_DIV-GHOST cycles.
- **Full frame:** 4·REFRESH_DIV cycles.
- **Counter widths:** $clog2 of each divider, minimum 1. Wrap is explicit compare-to-terminal, never natural overflow.

## Structure
- **Package stopwatch_pkg:**
  - Slot index constants SLOT_SEC_R..SLOT_MIN_L.
  - Adjust-select constants matching the counter's adj_sel encoding.
  - Active-high seven-segment pattern constants for 0–9, SEG_DASH and SEG_BLANK.
- **Sub-module seg7_decode:** purely combinational, 5-bit value → 7-bit active-high pattern; instantiated once on the muxed digit.
- **Top:** scan counter, blink counter, snapshot register, slot mux, blank/dp logic and the output register.

## Test plan
Bench parameters: REFRESH_DIV=8, GHOST=2, BLINK_DIV=20, ACTIVE_LOW=1.

- **Basic scan.** Stimulus: digits 1,2,3,4 (min_l..sec_r), reset released.
  - an cycles 1110, 1101, 1011, 0111, each low for 6 of 8 cycles, with 1111 for 2 cycles between.
  - seg = 0x19 (4), 0x30 (3), 0x24 (2), 0x79 (1) respectively.
  - dp=0 only in the an=1011 slot.
- **Snapshot atomicity.** Stimulus: change sec_r 4→5 while slot 2 is active.
  - Slot 0 shows 4 until the next frame start.
  - 5 first appears at the 2nd frame's slot 0.
- **Decode range.** Stimulus: sec_r=12, then 20.
  - seg = 0x3F (dash) for 12.
  - seg = 0x7F (blank) for 20.
- **Adjust blink.** Stimulus: adj_en=1, adj_sel=2, sec_l=3.
  - Slot 1 alternates between 0x30 and 0x7F every 20 cycles; other digits are steady.
  - With adj_sel=5, no digit blinks.
- **Leading zero.** Stimulus: blank_lz=1, min_l=0.
  - Slot 3 seg = 0x7F.
  - With adj_en=1, adj_sel=0 added, slot 3 shows 0x40 (zero) during blink_phase=0.
- **Pause and reset.** Stimulus: paused=1, then rst asserted mid-slot 2.
  - dp in slot 2 toggles every 20 cycles while paused.
  - One cycle after rst: an=1111, seg=0x7F, dp=1.
  - After release: scan restarts at slot 0 with snapshot 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared slot, adjust-select and seven-segment constants for the stopwatch display
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SLOT_SEC_R = 2'd0,
        SLOT_SEC_L = 2'd1,
        SLOT_MIN_R = 2'd2,
        SLOT_MIN_L = 2'd3
    } slot_t;

    localparam logic [2:0] ADJ_MIN_L = 3'd0;
    localparam logic [2:0] ADJ_MIN_R = 3'd1;
    localparam logic [2:0] ADJ_SEC_L = 3'd2;
    localparam logic [2:0] ADJ_SEC_R = 3'd3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // The counter numbers digits left to right, the scan numbers them right to left.
    function automatic logic [2:0] slot_adj(input slot_t slot);
        return slot == SLOT_SEC_R ? ADJ_SEC_R :
               slot == SLOT_SEC_L ? ADJ_SEC_L :
               slot == SLOT_MIN_R ? ADJ_MIN_R : ADJ_MIN_L;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 5-bit digit value to active-high seven-segment pattern (bit0 = a)
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [4:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!val_i[4]) begin
            case (val_i[3:0])
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 4-digit seven-segment driver with blink, pause dot, zero blanking and dead time
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST       = 4,
    parameter int BLINK_DIV   = 25000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] min_l,
    input  logic [4:0] min_r,
    input  logic [4:0] sec_l,
    input  logic [4:0] sec_r,
    input  logic       paused,
    input  logic       adj_en,
    input  logic [2:0] adj_sel,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GHOST  = CW'(GHOST);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic          POL1       = (ACTIVE_LOW != 0);
    localparam logic [6:0]    POL7       = {7{POL1}};
    localparam logic [3:0]    POL4       = {4{POL1}};

    logic [CW-1:0]     cnt_q, cnt_d;
    slot_t             slot_q, slot_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [3:0][4:0]   snap_q, snap_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        pattern;
    logic              blank;

    seg7_decode u_decode (
        .val_i (snap_d[slot_q]),
        .seg_o (pattern)
    );

    // The mux reads the next-state snapshot so a frame-start load is visible in the same output beat.
    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        slot_d  = (cnt_q == CNT_LAST) ? slot_t'(slot_q + 2'd1) : slot_q;
        bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
        phase_d = phase_q ^ (bcnt_q == BLINK_LAST);
        snap_d  = (slot_q == SLOT_SEC_R && cnt_q == '0) ? {min_l, min_r, sec_l, sec_r} : snap_q;
        blank   = (adj_en && adj_sel == slot_adj(slot_q) && phase_q) ||
                  (blank_lz && slot_q == SLOT_MIN_L && snap_d[SLOT_MIN_L] == 5'd0 &&
                   !(adj_en && adj_sel == ADJ_MIN_L));
        seg_d   = (blank ? SEG_BLANK : pattern) ^ POL7;
        dp_d    = (slot_q == SLOT_MIN_R && !(paused && phase_q)) ^ POL1;
        an_d    = (cnt_q >= CNT_GHOST) ? (4'b0001 << slot_q) ^ POL4 : POL4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            slot_q  <= SLOT_SEC_R;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            seg_q   <= POL7;
            dp_q    <= POL1;
            an_q    <= POL4;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed stimulus with a per-cycle arithmetic model and literal checkpoints
module tb_stopwatch_display;

    localparam int RD = 8;
    localparam int GH = 2;
    localparam int BD = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] min_l = '0, min_r = '0, sec_l = '0, sec_r = '0;
    logic       paused = 1'b0, adj_en = 1'b0, blank_lz = 1'b0;
    logic [2:0] adj_sel = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int vectors = 0;
    int miscompares = 0;

    stopwatch_display #(
        .REFRESH_DIV (RD),
        .GHOST       (GH),
        .BLINK_DIV   (BD),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .min_l    (min_l),
        .min_r    (min_r),
        .sec_l    (sec_l),
        .sec_r    (sec_r),
        .paused   (paused),
        .adj_en   (adj_en),
        .adj_sel  (adj_sel),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pattern(input logic [4:0] v);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v >= 5'd16) return 7'h00;
        if (v >= 5'd10) return 7'h40;
        return tbl[v[3:0]];
    endfunction

    // Model: position in the scan follows from the cycle count since reset.
    int         t = 0;
    int         m_cnt, m_slot, m_ph;
    bit         armed = 0;
    logic [4:0] snap_m [4];
    logic [6:0] p, e_seg;
    logic       e_dp;
    logic [3:0] e_an;

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            snap_m = '{default: 5'd0};
            e_seg = 7'h7F;
            e_dp = 1'b1;
            e_an = 4'hF;
            armed = 1;
        end else if (armed) begin
            m_cnt = t % RD;
            m_slot = (t / RD) % 4;
            m_ph = (t / BD) % 2;
            if (t % (4 * RD) == 0) begin
                snap_m[0] = sec_r;
                snap_m[1] = sec_l;
                snap_m[2] = min_r;
                snap_m[3] = min_l;
            end
            p = pattern(snap_m[m_slot]);
            if ((adj_en && int'(adj_sel) == 3 - m_slot && m_ph == 1) ||
                (m_slot == 3 && blank_lz && snap_m[3] == 5'd0 && !(adj_en && adj_sel == 3'd0)))
                p = 7'h00;
            e_seg = ~p;
            e_dp = !(m_slot == 2 && !(paused && m_ph == 1));
            e_an = (m_cnt >= GH) ? ~(4'b0001 << m_slot) : 4'hF;
            t++;
        end
        if (armed) begin
            #1;
            vectors++;
            if ({seg, dp, an} !== {e_seg, e_dp, e_an}) begin
                miscompares++;
                $display("FAIL model t=%0d: got seg=%h dp=%b an=%b, required seg=%h dp=%b an=%b",
                         t, seg, dp, an, e_seg, e_dp, e_an);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] tgt);
        int n;
        n = 0;
        @(negedge clk);
        while (an !== tgt && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (an !== tgt) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_an: an=%b required %b within 200 cycles", an, tgt);
        end
    endtask

    task automatic settle_to(input int k);
        wait_an(4'b0111);
        wait_an(4'b1110);
        if (k != 0) wait_an(~(4'b0001 << k));
    endtask

    task automatic ghost_count(input string name, input int exp_seg);
        int n;
        n = 0;
        @(negedge clk);
        while (an === 4'hF && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({name, "_ghost"}, n, GH);
        check({name, "_an"}, int'(an), 4'b1110);
        check({name, "_seg"}, int'(seg), exp_seg);
    endtask

    initial begin
        int m;
        bit s_a, s_b, bad;
        repeat (3) @(negedge clk);
        check("reset_an", int'(an), 4'hF);
        check("reset_seg", int'(seg), 7'h7F);
        check("reset_dp", int'(dp), 1);
        min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
        rst = 1'b0;
        ghost_count("first", 7'h19);
        m = 0;
        while (an === 4'b1110 && m < 50) begin
            m++;
            @(negedge clk);
        end
        check("slot_width", m, RD - GH);
        wait_an(4'b1101);
        check("slot1_seg", int'(seg), 7'h30);
        check("slot1_dp", int'(dp), 1);
        wait_an(4'b1011);
        check("slot2_seg", int'(seg), 7'h24);
        check("slot2_dp", int'(dp), 0);
        wait_an(4'b0111);
        check("slot3_seg", int'(seg), 7'h79);
        check("slot3_dp", int'(dp), 1);
        // snapshot atomicity
        wait_an(4'b1011);
        sec_r = 5'd5;
        wait_an(4'b1110);
        check("snap_new", int'(seg), 7'h12);
        sec_r = 5'd6;
        @(negedge clk);
        check("snap_hold", int'(seg), 7'h12);
        // decode range
        sec_r = 5'd12;
        settle_to(0);
        check("decode_dash", int'(seg), 7'h3F);
        sec_r = 5'd20;
        settle_to(0);
        check("decode_blank", int'(seg), 7'h7F);
        sec_r = 5'd4;
        settle_to(0);
        // adjust blink on sec_l
        adj_en = 1'b1; adj_sel = 3'd2;
        s_a = 0; s_b = 0; bad = 0;
        repeat (320) begin
            @(negedge clk);
            if (an === 4'b1101 && seg === 7'h30) s_a = 1;
            if (an === 4'b1101 && seg === 7'h7F) s_b = 1;
            if (an === 4'b1110 && seg !== 7'h19) bad = 1;
        end
        check("blink_digit", int'(s_a), 1);
        check("blink_blank", int'(s_b), 1);
        check("blink_steady_other", int'(bad), 0);
        adj_sel = 3'd5;
        bad = 0;
        repeat (160) begin
            @(negedge clk);
            if (an === 4'b1101 && seg !== 7'h30) bad = 1;
        end
        check("no_blink_sel5", int'(bad), 0);
        // leading zero
        adj_en = 1'b0; blank_lz = 1'b1; min_l = 5'd0;
        settle_to(3);
        check("lz_blank", int'(seg), 7'h7F);
        adj_en = 1'b1; adj_sel = 3'd0;
        s_a = 0;
        repeat (320) begin
            @(negedge clk);
            if (an === 4'b0111 && seg === 7'h40) s_a = 1;
        end
        check("lz_adj_zero", int'(s_a), 1);
        // pause dot
        adj_en = 1'b0; blank_lz = 1'b0; paused = 1'b1;
        s_a = 0; s_b = 0;
        repeat (320) begin
            @(negedge clk);
            if (an === 4'b1011 && dp === 1'b0) s_a = 1;
            if (an === 4'b1011 && dp === 1'b1) s_b = 1;
        end
        check("pause_dp_on", int'(s_a), 1);
        check("pause_dp_off", int'(s_b), 1);
        // reset mid slot 2
        wait_an(4'b1011);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", int'(an), 4'hF);
        check("midrst_seg", int'(seg), 7'h7F);
        check("midrst_dp", int'(dp), 1);
        sec_r = 5'd8;
        paused = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ghost_count("restart", 7'h00);
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
